// File: rtl/acc_responder_adapter.sv
// acc_responder_adapter: responder endpoint of the accelerator request/response channel.
// Latency: requests issue combinationally (0 cycles); a result reaches p one cycle after it is captured.
// Backpressure: q stalls while the tag FIFO is full or the accelerator is busy; p holds while p_ready_i is low.
//
// Optional feature macro: ACC_RSP_ADDR_CHECK_EN
//   defined   - requests with q_addr_i != AccAddr are accepted as bypass entries
//               and answered in order with error=1, data=0, without being issued.
//   undefined - q_addr_i is ignored and every request is issued.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   q_valid_i/q_ready_o, q_id_i,       offload request channel (id, address,
//   q_addr_i, q_instr_i, q_rs_i          instruction, packed operands, rs[0] in LSBs)
//   p_valid_o/p_ready_i, p_id_o,       response channel (echoed id, result, error)
//   p_data_o, p_error_o
//   exe_valid_o/exe_ready_i,           issue port to the accelerator
//   exe_instr_o, exe_rs_o
//   exe_rsp_valid_i, exe_rsp_data_i,   accelerator result pulse (no backpressure)
//   exe_rsp_error_i
//   outstanding_o                      tag FIFO occupancy

// Generic synchronous FIFO: registered storage, occupancy-based full/empty.
// Latency: a pushed word is visible at rdata the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module acc_rsp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr;
  logic [PtrW-1:0]  rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FullCnt);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Depth is a power of two, so the pointers wrap modulo Depth naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PtrW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PtrW+1)'(1);
        2'b01:   count <= count - (PtrW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module acc_responder_adapter #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned NumRs      = 2,
  parameter int unsigned ExtIdWidth = 2,
  parameter int unsigned AddrWidth  = 8,
  parameter int unsigned AccAddr    = 0,
  parameter int unsigned Depth      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          q_valid_i,
  output logic                          q_ready_o,
  input  logic [ExtIdWidth-1:0]         q_id_i,
  input  logic [AddrWidth-1:0]          q_addr_i,
  input  logic [31:0]                   q_instr_i,
  input  logic [NumRs*DataWidth-1:0]    q_rs_i,
  output logic                          p_valid_o,
  input  logic                          p_ready_i,
  output logic [ExtIdWidth-1:0]         p_id_o,
  output logic [DataWidth-1:0]          p_data_o,
  output logic                          p_error_o,
  output logic                          exe_valid_o,
  input  logic                          exe_ready_i,
  output logic [31:0]                   exe_instr_o,
  output logic [NumRs*DataWidth-1:0]    exe_rs_o,
  input  logic                          exe_rsp_valid_i,
  input  logic [DataWidth-1:0]          exe_rsp_data_i,
  input  logic                          exe_rsp_error_i,
  output logic [$clog2(Depth):0]        outstanding_o
);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  typedef struct packed {
    logic [ExtIdWidth-1:0] id;
    logic                  bypass;
  } tag_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 error;
  } res_t;

  logic            bypass;
  logic            issue;

  tag_t            tag_in;
  tag_t            tag_head;
  logic            tag_push;
  logic            tag_pop;
  logic            tag_full;
  logic            tag_empty;
  logic [CntW-1:0] tag_count;

  res_t            res_in;
  res_t            res_head;
  logic            res_push;
  logic            res_pop;
  logic            res_full;
  logic            res_empty;
  logic [CntW-1:0] res_count;

  // Issued requests still waiting for their accelerator result. A result
  // pulse is only legal while this is non-zero.
  logic [CntW-1:0] pending;
  logic            rsp_legal;

`ifdef ACC_RSP_ADDR_CHECK_EN
  assign bypass = (q_addr_i != AddrWidth'(AccAddr));
`else
  logic unused_addr;
  assign bypass      = 1'b0;
  assign unused_addr = ^{q_addr_i, AddrWidth'(AccAddr)};
`endif

  // Request side. A full tag FIFO blocks acceptance even when a response
  // pops in the same cycle, keeping q_ready_o independent of p_ready_i.
  assign q_ready_o   = !rst_i && !tag_full && (bypass || exe_ready_i);
  assign exe_valid_o = q_valid_i && !rst_i && !tag_full && !bypass;
  assign exe_instr_o = q_instr_i;
  assign exe_rs_o    = q_rs_i;
  assign issue       = exe_valid_o && exe_ready_i;

  assign tag_push    = q_valid_i && q_ready_o;
  assign tag_in.id     = q_id_i;
  assign tag_in.bypass = bypass;

  acc_rsp_fifo #(
    .Width ($bits(tag_t)),
    .Depth (Depth)
  ) tag_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (tag_push),
    .wdata (tag_in),
    .pop   (tag_pop),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign outstanding_o = tag_count;

  // Result side. Illegal pulses (no issued request awaiting a result, or
  // storage full) are dropped so the FIFO pairing with tags never skews.
  assign rsp_legal    = (pending != '0) && !res_full;
  assign res_push     = exe_rsp_valid_i && rsp_legal && !rst_i;
  assign res_in.data  = exe_rsp_data_i;
  assign res_in.error = exe_rsp_error_i;

  acc_rsp_fifo #(
    .Width ($bits(res_t)),
    .Depth (Depth)
  ) res_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (res_push),
    .wdata (res_in),
    .pop   (res_pop),
    .rdata (res_head),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending <= '0;
    end else begin
      case ({issue, res_push})
        2'b10:   pending <= pending + CntW'(1);
        2'b01:   pending <= pending - CntW'(1);
        default: pending <= pending;
      endcase
    end
  end

  // Response side, combinational from the two FIFO heads. Bypass entries
  // answer immediately with an error; issued entries wait for their result.
  always_comb begin
    p_valid_o = 1'b0;
    p_data_o  = '0;
    p_error_o = 1'b0;
    if (!rst_i && !tag_empty) begin
      if (tag_head.bypass) begin
        p_valid_o = 1'b1;
        p_error_o = 1'b1;
      end else begin
        p_valid_o = !res_empty;
        p_data_o  = res_head.data;
        p_error_o = res_head.error;
      end
    end
  end

  assign p_id_o  = tag_head.id;
  assign tag_pop = p_valid_o && p_ready_i;
  assign res_pop = tag_pop && !tag_head.bypass;

  // The accelerator must never answer without an issued request waiting.
  rsp_legal_a: assert property (@(posedge clk_i) disable iff (rst_i)
    exe_rsp_valid_i |-> rsp_legal);

  // Stored results always belong to outstanding tags.
  res_le_tag_a: assert property (@(posedge clk_i) disable iff (rst_i)
    res_count <= tag_count);
endmodule

// File: tb/tb_acc_responder_adapter.sv
// tb_acc_responder_adapter: directed and randomized checks against a queue-based reference model.
// Latency: one step per clock; inputs driven #1 after posedge, outputs sampled at negedge.
// Backpressure: p_ready and exe_ready are driven directly by the stimulus.
module tb_acc_responder_adapter;
  localparam int DW       = 32;
  localparam int NR       = 2;
  localparam int IW       = 2;
  localparam int AW       = 8;
  localparam int DEPTH    = 4;
  localparam int ACC_ADDR = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    q_valid;
  logic                    q_ready;
  logic [IW-1:0]           q_id;
  logic [AW-1:0]           q_addr;
  logic [31:0]             q_instr;
  logic [NR*DW-1:0]        q_rs;
  logic                    p_valid;
  logic                    p_ready;
  logic [IW-1:0]           p_id;
  logic [DW-1:0]           p_data;
  logic                    p_error;
  logic                    exe_valid;
  logic                    exe_ready;
  logic [31:0]             exe_instr;
  logic [NR*DW-1:0]        exe_rs;
  logic                    rsp_valid;
  logic [DW-1:0]           rsp_data;
  logic                    rsp_error;
  logic [$clog2(DEPTH):0]  outstanding;

  always #5 clk = ~clk;

  acc_responder_adapter #(
    .DataWidth  (DW),
    .NumRs      (NR),
    .ExtIdWidth (IW),
    .AddrWidth  (AW),
    .AccAddr    (ACC_ADDR),
    .Depth      (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .q_valid_i       (q_valid),
    .q_ready_o       (q_ready),
    .q_id_i          (q_id),
    .q_addr_i        (q_addr),
    .q_instr_i       (q_instr),
    .q_rs_i          (q_rs),
    .p_valid_o       (p_valid),
    .p_ready_i       (p_ready),
    .p_id_o          (p_id),
    .p_data_o        (p_data),
    .p_error_o       (p_error),
    .exe_valid_o     (exe_valid),
    .exe_ready_i     (exe_ready),
    .exe_instr_o     (exe_instr),
    .exe_rs_o        (exe_rs),
    .exe_rsp_valid_i (rsp_valid),
    .exe_rsp_data_i  (rsp_data),
    .exe_rsp_error_i (rsp_error),
    .outstanding_o   (outstanding)
  );

  // Expected responses in acceptance order; avail marks a result delivered.
  typedef struct {
    logic [IW-1:0] id;
    bit            byp;
    logic [DW-1:0] data;
    bit            err;
    bit            avail;
  } exp_t;
  exp_t model_q[$];

  // Accelerator stand-in: in-order results, wait_cyc cycles of extra delay.
  typedef struct {
    logic [DW-1:0] data;
    bit            err;
    int            wait_cyc;
  } acc_t;
  acc_t acc_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of traffic: drive, check at negedge, advance the model.
  task automatic step(input bit qv, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                      input logic [31:0] instr, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input bit pr, input bit er, input int lat);
    bit   full_m, byp, exp_qrdy, exp_exev, exp_pv, pulse, found;
    exp_t e;
    acc_t r;
    q_valid   = qv;
    q_id      = id;
    q_addr    = addr;
    q_instr   = instr;
    q_rs      = {b, a};
    p_ready   = pr;
    exe_ready = er;
    pulse     = 1'b0;
    if (acc_q.size() > 0 && acc_q[0].wait_cyc == 0) begin
      r         = acc_q.pop_front();
      pulse     = 1'b1;
      rsp_data  = r.data;
      rsp_error = r.err;
    end else begin
      rsp_data  = $urandom;
      rsp_error = 1'($urandom_range(0, 1));
    end
    rsp_valid = pulse;

    @(negedge clk);
    full_m = (model_q.size() == DEPTH);
`ifdef ACC_RSP_ADDR_CHECK_EN
    byp = (addr != AW'(ACC_ADDR));
`else
    byp = 1'b0;
`endif
    exp_qrdy = !full_m && (byp || er);
    exp_exev = qv && !full_m && !byp;
    exp_pv   = (model_q.size() > 0) && (model_q[0].byp || model_q[0].avail);

    check_eq("q_ready", q_ready, exp_qrdy);
    check_eq("exe_valid", exe_valid, exp_exev);
    check_eq("outstanding", outstanding, model_q.size());
    check_eq("p_valid", p_valid, exp_pv);
    if (qv) check_eq("exe_payload", {exe_instr, exe_rs}, {instr, b, a});
    if (exp_pv) begin
      check_eq("p_id", p_id, model_q[0].id);
      check_eq("p_data", p_data, model_q[0].byp ? '0 : model_q[0].data);
      check_eq("p_error", p_error, model_q[0].byp ? 1'b1 : model_q[0].err);
    end

    if (exp_pv && pr) void'(model_q.pop_front());
    if (pulse) begin
      found = 1'b0;
      for (int i = 0; i < model_q.size(); i++) begin
        if (!found && !model_q[i].byp && !model_q[i].avail) begin
          model_q[i].avail = 1'b1;
          found = 1'b1;
        end
      end
    end
    for (int i = 0; i < acc_q.size(); i++) begin
      if (acc_q[i].wait_cyc > 0) acc_q[i].wait_cyc--;
    end
    if (qv && exp_qrdy) begin
      e.id = id; e.byp = byp; e.data = a + b; e.err = instr[31]; e.avail = 1'b0;
      model_q.push_back(e);
      if (!byp) begin
        r.data = a + b; r.err = instr[31]; r.wait_cyc = lat;
        acc_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit pr);
    for (int i = 0; i < n; i++) step(1'b0, '0, AW'(ACC_ADDR), 32'h0, '0, '0, pr, 1'b1, 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    q_valid   = 1'b1;
    q_addr    = AW'(ACC_ADDR);
    exe_ready = 1'b1;
    p_ready   = 1'b1;
    rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_q_ready", q_ready, 1'b0);
    check_eq("rst_p_valid", p_valid, 1'b0);
    check_eq("rst_exe_valid", exe_valid, 1'b0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    q_valid = 1'b0;
    model_q.delete();
    acc_q.delete();
    @(negedge clk);
    check_eq("post_rst_outstanding", outstanding, 0);
    check_eq("post_rst_p_valid", p_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] addr;
    rst = 1'b1; q_valid = 1'b0; q_id = '0; q_addr = '0; q_instr = '0; q_rs = '0;
    p_ready = 1'b0; exe_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_error = 1'b0;
    do_reset();

    // Single request, result two cycles after issue.
    step(1'b1, 2'b10, AW'(ACC_ADDR), 32'h1, 5, 7, 1'b1, 1'b1, 1);
    idle(5, 1'b1);

    // Fill with p stalled; fifth request waits for a freed slot.
    for (int i = 0; i < 5; i++) step(1'b1, IW'(i), AW'(ACC_ADDR), 32'(i), DW'(i), 1, 1'b0, 1'b1, 0);
    step(1'b1, 2'd0, AW'(ACC_ADDR), 32'h4, 4, 1, 1'b1, 1'b1, 0);
    step(1'b1, 2'd0, AW'(ACC_ADDR), 32'h4, 4, 1, 1'b0, 1'b1, 0);
    idle(8, 1'b1);

    // Three results with p_ready toggling.
    step(1'b1, 2'd0, AW'(ACC_ADDR), 32'h0, 1, 0, 1'b0, 1'b1, 0);
    step(1'b1, 2'd1, AW'(ACC_ADDR), 32'h8000_0000, 2, 0, 1'b0, 1'b1, 1);
    step(1'b1, 2'd3, AW'(ACC_ADDR), 32'h0, 3, 0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++) idle(1, 1'(i % 2));

    // Accelerator busy: request held, not accepted.
    step(1'b1, 2'd2, AW'(ACC_ADDR), 32'h5, 9, 9, 1'b1, 1'b0, 0);
    step(1'b1, 2'd2, AW'(ACC_ADDR), 32'h5, 9, 9, 1'b1, 1'b0, 0);
    step(1'b1, 2'd2, AW'(ACC_ADDR), 32'h5, 9, 9, 1'b1, 1'b1, 0);
    idle(4, 1'b1);

    // Address mix: the middle one is a bypass when the address check is built in.
    step(1'b1, 2'd0, AW'(3), 32'h0, 10, 1, 1'b1, 1'b1, 2);
    step(1'b1, 2'd1, AW'(5), 32'h0, 20, 2, 1'b1, 1'b1, 2);
    step(1'b1, 2'd2, AW'(3), 32'h0, 30, 3, 1'b1, 1'b1, 2);
    idle(10, 1'b1);

    // Reset with three outstanding, then traffic as from cold.
    for (int i = 0; i < 3; i++) step(1'b1, IW'(i), AW'(ACC_ADDR), 32'h0, DW'(i), 2, 1'b0, 1'b1, 3);
    do_reset();
    step(1'b1, 2'b01, AW'(ACC_ADDR), 32'h0, 40, 2, 1'b1, 1'b1, 0);
    idle(4, 1'b1);

    // Randomized phases with different pressure on each side.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 400; i++) begin
        addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'(ACC_ADDR);
        step(1'($urandom_range(0, 99) < 70), IW'($urandom), addr, $urandom, $urandom, $urandom,
             1'($urandom_range(0, 99) < (ph == 0 ? 80 : (ph == 1 ? 30 : 60))),
             1'($urandom_range(0, 99) < (ph == 2 ? 40 : 85)),
             int'($urandom_range(0, 3)));
      end
      idle(30, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/acc_responder_adapter.md
Name: acc_responder_adapter

Overview:
- Responder-side endpoint of the accelerator request/response channel. It terminates one extended-ID master port of the accelerator interconnect.
- Accepts q-channel offload requests and issues them in order to a simple execute port of a single accelerator.
- Buffers results and returns p-channel responses in request order, echoing the extended ID so the interconnect's response crossbar can route them.
- Bounds outstanding transactions with an ID/tag FIFO.

Parameters:
- DataWidth, 32, operand/result width.
- NumRs, 2, number of source operands per request.
- ExtIdWidth, 2, request ID width (1 + sender index bits).
- AddrWidth, 8, request address width.
- AccAddr, 0, address this responder answers to (used only with the optional feature).
- Depth, 4, maximum outstanding requests; tag and result FIFO depth; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- q_valid_i  in  1  request valid.
- q_ready_o  out  1  request ready.
- q_id_i  in  ExtIdWidth  request ID.
- q_addr_i  in  AddrWidth  request address.
- q_instr_i  in  32  offloaded instruction.
- q_rs_i  in  NumRs*DataWidth  source operands; rs[0] in the LSBs.
- p_valid_o  out  1  response valid.
- p_ready_i  in  1  response ready.
- p_id_o  out  ExtIdWidth  echoed request ID.
- p_data_o  out  DataWidth  result.
- p_error_o  out  1  error flag.
- exe_valid_o  out  1  issue to accelerator.
- exe_ready_i  in  1  accelerator can accept.
- exe_instr_o  out  32  issued instruction.
- exe_rs_o  out  NumRs*DataWidth  issued operands.
- exe_rsp_valid_i  in  1  result valid; single-cycle pulse; cannot be backpressured.
- exe_rsp_data_i  in  DataWidth  result data.
- exe_rsp_error_i  in  1  result error.
- outstanding_o  out  $clog2(Depth)+1  tag FIFO occupancy.

Behaviour:

Tag FIFO (Depth entries of {id, bypass}):
- Push on q handshake (q_valid_i && q_ready_o).
- Pop on p handshake (p_valid_o && p_ready_i).
- When full, no request is accepted. A same-cycle pop does not free a slot: full blocks acceptance even if a pop occurs that cycle.

Request acceptance and issue:
- bypass = 0 unless the optional feature marks the request.
- q_ready_o = !rst_i && !tag_full && (bypass || exe_ready_i).
- exe_valid_o = q_valid_i && !rst_i && !tag_full && !bypass.
- exe_instr_o and exe_rs_o pass through combinationally from q_instr_i and q_rs_i; issue latency is 0 cycles.
- A non-bypass request is issued exactly when it is accepted.

Result FIFO (Depth entries of {data, error}):
- Pushes whenever exe_rsp_valid_i is high.
- The accelerator returns results in issue order.
- Overflow cannot occur because issues are limited by tag occupancy. A result arriving while the result FIFO is full, or with no non-bypass tag outstanding, is illegal: flag it with an assertion and drop the result.

Response output (combinational from FIFO heads):
- Head tag bypass=1: p_valid_o=1, p_data_o=0, p_error_o=1.
- Head tag bypass=0: p_valid_o = result FIFO non-empty; p_data_o and p_error_o come from the result head.
- With the tag FIFO empty: p_valid_o=0.
- p_id_o = head tag id.
- On p handshake: pop the tag, and also pop the result if the tag is non-bypass.
- A result pushed in cycle N appears on p no earlier than cycle N+1.
- Holding p_ready_i low keeps p_* stable (standard valid/ready: no retraction, no payload change).

Simultaneous events:
- Result push and result pop in the same cycle are both performed; occupancy is unchanged.
- Tag push and pop in the same cycle: occupancy is unchanged (only possible when not full).

Pointers:
- Read/write pointers are $clog2(Depth) bits and wrap modulo Depth.
- Full and empty are derived from occupancy counters.

Reset:
- All FIFOs are emptied and outstanding_o=0.
- p_valid_o=0, q_ready_o=0, exe_valid_o=0 while rst_i is high.
- Reset mid-operation discards all outstanding tags and results. The accelerator is reset in the same cycle, which is a system requirement.

Optional Feature:
- Macro: ACC_RSP_ADDR_CHECK_EN.
- Defined: a request with q_addr_i != AccAddr is accepted with bypass=1. It is not issued and is answered in order with error=1, data=0.
- Undefined: q_addr_i is ignored, bypass is always 0, and every request is issued.

Test Plan:
- Single request id=2'b10, rs={5,7}; accelerator returns 12 two cycles later. Expect exe_valid_o in the accept cycle, then p_id=2'b10, p_data=12, p_error=0 one cycle after the result.
- Depth=4, p_ready_i=0, five requests. Expect the 5th held with q_ready_o=0 and outstanding_o=4. A p handshake frees the slot; the 5th is accepted the following cycle.
- Results 1,2,3 for ids 0,1,3 with p_ready_i toggling 1/0. Expect responses in issue order, each stable while stalled.
- exe_ready_i=0 with q_valid_i=1. Expect q_ready_o=0, no tag push, exe_valid_o=1 held.
- With ACC_RSP_ADDR_CHECK_EN, AccAddr=3: requests addr 3 (id0), addr 5 (id1), addr 3 (id2). Expect responses id0 result, then id1 error=1 data=0 after id0, then id2; only two issues.
- Assert rst_i with 3 outstanding. Next cycle: outstanding_o=0, p_valid_o=0, and subsequent traffic behaves as from cold reset.
